// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: RV32I opcode encodings and the decoded-record layout.
// is_legal_opcode() backs the DECODE_ILLEGAL_TRAP_EN build option.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            op_lui, op_auipc, op_jal, op_jalr, op_br,
            op_load, op_store, op_imm, op_reg, op_csr: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

package control_itf;
    import rv32i_types::*;

    typedef struct packed {
        logic [31:0] pc;
        rv32i_opcode opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
        logic        rd_we;
    } instruction_decode;

    // addi x0,x0,0 with pc zero; callers substitute the real pc
    localparam instruction_decode NOP_DECODE = '{
        pc:     32'h0,
        opcode: op_imm,
        rd:     5'd0,
        funct3: 3'd0,
        rs1:    5'd0,
        rs2:    5'd0,
        funct7: 7'd0,
        i_imm:  32'h0,
        s_imm:  32'h0,
        b_imm:  32'h0,
        u_imm:  32'h0,
        j_imm:  32'h0,
        rd_we:  1'b0
    };

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// decode_stage binds the slave modport; its neighbours (or a bench) drive the master side.
interface decode_stage_if;
    import control_itf::*;

    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       in_instr_i;
    logic [31:0]       in_pc_i;
    logic              out_valid_o;
    logic              out_ready_i;
    instruction_decode idecode_o;
    logic              illegal_seen_o;

    modport master (
        output flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, idecode_o, illegal_seen_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, idecode_o, illegal_seen_o
    );

endinterface

// File: rtl/decode_stage_instr_field_decoder.sv
// Combinational instruction word + pc to decoded record.
// With DECODE_ILLEGAL_TRAP_EN defined, unknown opcodes become the canonical NOP.
module instr_field_decoder
    import rv32i_types::*;
    import control_itf::*;
(
    input  logic [31:0]       instr,
    input  logic [31:0]       pc,
    output instruction_decode rec
);

    instruction_decode raw;

    always_comb begin
        raw        = '0;
        raw.pc     = pc;
        raw.opcode = rv32i_opcode'(instr[6:0]);
        raw.rd     = instr[11:7];
        raw.funct3 = instr[14:12];
        raw.rs1    = instr[19:15];
        raw.rs2    = instr[24:20];
        raw.funct7 = instr[31:25];
        raw.i_imm  = {{20{instr[31]}}, instr[31:20]};
        raw.s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        raw.b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        raw.u_imm  = {instr[31:12], 12'h000};
        raw.j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        // writes to x0 are architecturally dropped, so never flag them
        case (instr[6:0])
            op_lui, op_auipc, op_jal, op_jalr, op_load, op_imm, op_reg:
                raw.rd_we = (instr[11:7] != 5'd0);
            default:
                raw.rd_we = 1'b0;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_comb begin
        rec = raw;
        if (!is_legal_opcode(instr[6:0])) begin
            rec    = NOP_DECODE;
            rec.pc = pc;
        end
    end
`else
    assign rec = raw;
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetched words at enqueue and buffers records in a DEPTH-entry FIFO.
// DECODE_ILLEGAL_TRAP_EN enables NOP substitution of unknown opcodes and the sticky illegal flag.
module decode_stage
    import rv32i_types::*;
    import control_itf::*;
#(
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    instruction_decode mem [DEPTH];
    instruction_decode enq_rec;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ready depends only on the registered count, never on out_ready_i
    assign bus.in_ready_o  = (count != CNT_W'(DEPTH));
    assign bus.out_valid_o = (count != '0);
    assign push            = bus.in_valid_i & bus.in_ready_o;
    assign pop             = bus.out_valid_o & bus.out_ready_i;
    assign bus.idecode_o   = mem[rd_ptr];

    instr_field_decoder u_decoder (
        .instr (bus.in_instr_i),
        .pc    (bus.in_pc_i),
        .rec   (enq_rec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // a flush leaves storage intact; only a discarded flush-cycle push skips the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !bus.flush_i) begin
            mem[wr_ptr] <= enq_rec;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else if (push && !bus.flush_i && !is_legal_opcode(bus.in_instr_i[6:0])) begin
            illegal_seen <= 1'b1;
        end
    end

    assign bus.illegal_seen_o = illegal_seen;
`else
    assign bus.illegal_seen_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table, backpressure/wrap stream, flush and reset.
// Covers the DECODE_ILLEGAL_TRAP_EN build when that macro is defined for the bench too.
module tb_decode_stage;
    import rv32i_types::*;
    import control_itf::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0]       instr;
        logic [31:0]       pc;
        instruction_decode exp;
        logic              ill;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   m_cnt;
    int   next_k;
    int   expq[$];
    logic exp_ill;
    vec_t vecs[7];

    decode_stage_if bus ();

    decode_stage #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic instruction_decode mk(
        input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
        input logic [31:0] i_imm, input logic [31:0] s_imm, input logic [31:0] b_imm,
        input logic [31:0] u_imm, input logic [31:0] j_imm, input logic we);
        instruction_decode r;
        r.pc = pc;       r.opcode = rv32i_opcode'(op); r.rd = rd;   r.funct3 = f3;
        r.rs1 = rs1;     r.rs2 = rs2;                  r.funct7 = f7;
        r.i_imm = i_imm; r.s_imm = s_imm;              r.b_imm = b_imm;
        r.u_imm = u_imm; r.j_imm = j_imm;              r.rd_we = we;
        return r;
    endfunction

    // one handshake cycle against a count/queue model of addi x0,x0,k words at pc 0x1000+4k
    task automatic step(input logic v, input logic r);
        logic push_m;
        logic pop_m;
        int   e;
        bus.in_valid_i  = v;
        bus.out_ready_i = r;
        bus.in_instr_i  = 32'h0000_0013 | (32'(next_k) << 20);
        bus.in_pc_i     = 32'h1000 + 32'(next_k) * 4;
        check("s_out_valid", 256'(bus.out_valid_o), 256'(m_cnt != 0));
        check("s_in_ready", 256'(bus.in_ready_o), 256'(m_cnt != DEPTH));
        push_m = v && (m_cnt != DEPTH);
        pop_m  = r && (m_cnt != 0);
        if (pop_m) begin
            if (expq.size() == 0) begin
                check("s_underflow", 256'(1), 256'(0));
            end else begin
                e = expq.pop_front();
                check("s_head", {bus.idecode_o.pc, bus.idecode_o.i_imm},
                      {32'h1000 + 32'(e) * 4, 32'(e)});
            end
        end
        if (push_m) begin
            expq.push_back(next_k);
            next_k++;
        end
        m_cnt = m_cnt + int'(push_m) - int'(pop_m);
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_cnt   = 0;
        next_k  = 0;
        exp_ill = 1'b0;

        vecs[0] = '{32'h0050_0093, 32'h60, mk(32'h60, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'h00,
                    32'h5, 32'h1, 32'h800, 32'h0050_0000, 32'h804, 1'b1), 1'b0};
        vecs[1] = '{32'hFE00_0EE3, 32'h64, mk(32'h64, 7'h63, 5'd29, 3'd0, 5'd0, 5'd0, 7'h7F,
                    32'hFFFF_FFE0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFE00_0000, 32'hFFF0_07E0, 1'b0), 1'b0};
        vecs[2] = '{32'h1234_5137, 32'h68, mk(32'h68, 7'h37, 5'd2, 3'd5, 5'd8, 5'd3, 7'h09,
                    32'h123, 32'h122, 32'h122, 32'h1234_5000, 32'h4_5922, 1'b1), 1'b0};
        vecs[3] = '{32'h0050_A423, 32'h6C, mk(32'h6C, 7'h23, 5'd8, 3'd2, 5'd1, 5'd5, 7'h00,
                    32'h5, 32'h8, 32'h8, 32'h0050_A000, 32'h0_A804, 1'b0), 1'b0};
        vecs[4] = '{32'h0020_8033, 32'h70, mk(32'h70, 7'h33, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00,
                    32'h2, 32'h0, 32'h0, 32'h0020_8000, 32'h0_8002, 1'b0), 1'b0};
        vecs[5] = '{32'h0000_80E7, 32'h74, mk(32'h74, 7'h67, 5'd1, 3'd0, 5'd1, 5'd0, 7'h00,
                    32'h0, 32'h1, 32'h800, 32'h0000_8000, 32'h8000, 1'b1), 1'b0};
`ifdef DECODE_ILLEGAL_TRAP_EN
        vecs[6] = '{32'h0000_007F, 32'h78, mk(32'h78, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0), 1'b1};
`else
        vecs[6] = '{32'h0000_007F, 32'h78, mk(32'h78, 7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0), 1'b0};
`endif

        rst             = 1'b1;
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_instr_i  = '0;
        bus.in_pc_i     = '0;
        bus.out_ready_i = 1'b0;
        #2;
        check("rst_out_valid", 256'(bus.out_valid_o), 256'(0));
        check("rst_in_ready", 256'(bus.in_ready_o), 256'(1));
        check("rst_idecode", bus.idecode_o, 256'(0));
        check("rst_illegal", 256'(bus.illegal_seen_o), 256'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // mid-cycle reset with a record queued must clear everything without a clock edge
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = 32'h0050_0093;
        bus.in_pc_i    = 32'h60;
        tick();
        bus.in_valid_i = 1'b0;
        check("pre_rst_valid", 256'(bus.out_valid_o), 256'(1));
        #3 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 256'(bus.out_valid_o), 256'(0));
        check("async_rst_in_ready", 256'(bus.in_ready_o), 256'(1));
        check("async_rst_idecode", bus.idecode_o, 256'(0));
        #2 rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            bus.out_ready_i = 1'b1;
            bus.in_valid_i  = 1'b1;
            bus.in_instr_i  = vecs[i].instr;
            bus.in_pc_i     = vecs[i].pc;
            tick();
            bus.in_valid_i = 1'b0;
            exp_ill = exp_ill | vecs[i].ill;
            check($sformatf("vec%0d_valid", i), 256'(bus.out_valid_o), 256'(1));
            check($sformatf("vec%0d_record", i), bus.idecode_o, vecs[i].exp);
            check($sformatf("vec%0d_illegal", i), 256'(bus.illegal_seen_o), 256'(exp_ill));
            tick();
            check($sformatf("vec%0d_drained", i), 256'(bus.out_valid_o), 256'(0));
        end

        // fill under backpressure, then stream across pointer wrap, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 4 * DEPTH && expq.size() != 0; i++) step(1'b0, 1'b1);
        check("stream_drain_bound", 256'(expq.size()), 256'(0));
        step(1'b0, 1'b1);
        check("stream_all_pushed", 256'(next_k), 256'(4 * DEPTH - 1));

        // flush with two entries queued and a word offered in the flush cycle
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_instr_i  = 32'h0010_0013; bus.in_pc_i = 32'h300; tick();
        bus.in_instr_i  = 32'h0020_0013; bus.in_pc_i = 32'h304; tick();
        bus.flush_i     = 1'b1;
        bus.in_instr_i  = 32'h0030_0013; bus.in_pc_i = 32'h308; tick();
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        check("flush2_out_valid", 256'(bus.out_valid_o), 256'(0));
        check("flush2_in_ready", 256'(bus.in_ready_o), 256'(1));
        bus.in_valid_i  = 1'b1;
        bus.in_instr_i  = 32'h0040_0013; bus.in_pc_i = 32'h30C; tick();
        bus.in_valid_i  = 1'b0;
        check("flush2_next_pc", 256'(bus.idecode_o.pc), 256'(32'h30C));
        bus.out_ready_i = 1'b1;
        tick();
        check("flush2_single_entry", 256'(bus.out_valid_o), 256'(0));

        // flush beats a legal push and pop in the same cycle
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_instr_i  = 32'h0050_0013; bus.in_pc_i = 32'h400; tick();
        bus.flush_i     = 1'b1;
        bus.out_ready_i = 1'b1;
        bus.in_instr_i  = 32'h0060_0013; bus.in_pc_i = 32'h404; tick();
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        check("flush1_out_valid", 256'(bus.out_valid_o), 256'(0));
        tick();
        check("flush1_still_empty", 256'(bus.out_valid_o), 256'(0));

`ifdef DECODE_ILLEGAL_TRAP_EN
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_instr_i  = 32'h0000_007F; bus.in_pc_i = 32'h500; tick();
        bus.in_valid_i  = 1'b0;
        check("trap_nop_record", bus.idecode_o,
              mk(32'h500, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
        check("trap_illegal_set", 256'(bus.illegal_seen_o), 256'(1));
        bus.flush_i = 1'b1; tick();
        bus.flush_i = 1'b0; tick();
        check("trap_illegal_held", 256'(bus.illegal_seen_o), 256'(1));
`else
        check("no_trap_illegal", 256'(bus.illegal_seen_o), 256'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
